// File: rtl/axi_rd_bus_rr_if.sv
// AXI3 read-channel bundle, NP ports wide on the valid/ready and AR-field side,
// with a single broadcast R payload. The arbiter uses NP=N_MST upstream and NP=1 downstream.
interface axi_rd_bus_rr_if #(
  parameter int NP     = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [NP-1:0]        arvalid;
  logic [NP-1:0]        arready;
  logic [NP*ID_W-1:0]   arid;
  logic [NP*ADDR_W-1:0] araddr;
  logic [NP*4-1:0]      arlen;
  logic [NP*3-1:0]      arsize;
  logic [NP*2-1:0]      arburst;
  logic [NP*2-1:0]      arlock;
  logic [NP*4-1:0]      arcache;
  logic [NP*3-1:0]      arprot;
  logic [NP-1:0]        rvalid;
  logic [NP-1:0]        rready;
  logic [ID_W-1:0]      rid;
  logic [DATA_W-1:0]    rdata;
  logic [1:0]           rresp;
  logic                 rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_rd_bus_rr.sv
// N-master to 1-slave AXI3 read bus, one transaction in flight, round-robin arbitration.
// Define AXI_RD_BUS_FIXPRIO_EN for fixed priority (master 0 highest) instead.
module axi_rd_bus_rr #(
  parameter int N_MST  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_bus_rr_if.slave    s,
  axi_rd_bus_rr_if.master   m,
  output logic [N_MST-1:0]  grant,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t             state_q, state_d;
  logic [N_MST-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ar_sel;

  // First requester at or after rr_ptr, wrapping; rr_ptr stays 0 in fixed-priority mode.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    cand      = '0;
    for (int i = 0; i < N_MST; i++) begin
      pos = int'(rr_ptr_q) + i;
      if (pos >= N_MST) pos = pos - N_MST;
      cand = IDX_W'(pos);
      if (!win_found && s.arvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d = N_MST'(1) << win_idx;
          idx_d   = win_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m.arvalid[0] && m.arready[0]) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (m.rvalid[0] && m.rready[0] && m.rlast) begin
          state_d = ST_IDLE;
          grant_d = '0;
`ifdef AXI_RD_BUS_FIXPRIO_EN
          rr_ptr_d = rr_ptr_q;
`else
          rr_ptr_d = (idx_q == IDX_W'(N_MST - 1)) ? '0 : idx_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

  // AR fields park on master 0 outside ADDR so the slave sees stable values.
  assign ar_sel = (state_q == ST_ADDR) ? idx_q : '0;

  always_comb begin
    m.arid    = s.arid   [int'(ar_sel)*ID_W   +: ID_W];
    m.araddr  = s.araddr [int'(ar_sel)*ADDR_W +: ADDR_W];
    m.arlen   = s.arlen  [int'(ar_sel)*4      +: 4];
    m.arsize  = s.arsize [int'(ar_sel)*3      +: 3];
    m.arburst = s.arburst[int'(ar_sel)*2      +: 2];
    m.arlock  = s.arlock [int'(ar_sel)*2      +: 2];
    m.arcache = s.arcache[int'(ar_sel)*4      +: 4];
    m.arprot  = s.arprot [int'(ar_sel)*3      +: 3];
    m.arvalid[0] = (state_q == ST_ADDR) && s.arvalid[idx_q];
    m.rready[0]  = (state_q == ST_DATA) && s.rready[idx_q];
  end

  assign s.rid   = m.rid;
  assign s.rdata = m.rdata;
  assign s.rresp = m.rresp;
  assign s.rlast = m.rlast;

  for (genvar gi = 0; gi < N_MST; gi++) begin : g_demux
    assign s.arready[gi] = (state_q == ST_ADDR) && (idx_q == IDX_W'(gi)) && m.arready[0];
    assign s.rvalid[gi]  = (state_q == ST_DATA) && (idx_q == IDX_W'(gi)) && m.rvalid[0];
  end

endmodule

// File: tb/tb_axi_rd_bus_rr.sv
// Directed bench for axi_rd_bus_rr (N_MST=3): cycle vector table plus burst sequences.
// Expectations follow AXI_RD_BUS_FIXPRIO_EN when it is defined.
module tb_axi_rd_bus_rr;

`ifdef AXI_RD_BUS_FIXPRIO_EN
  localparam bit FIXPRIO = 1'b1;
`else
  localparam bit FIXPRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] grant;
  logic       busy;

  axi_rd_bus_rr_if #(.NP(3), .ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();
  axi_rd_bus_rr_if #(.NP(1), .ADDR_W(32), .DATA_W(32), .ID_W(4)) m_if ();

  axi_rd_bus_rr #(.N_MST(3), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .s     (s_if),
    .m     (m_if),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  arv;
    logic [2:0]  rrdy;
    logic        arrdy;
    logic        rv;
    logic        rl;
    logic [31:0] rd;
    logic [2:0]  e_grant;
    logic        e_busy;
    logic        e_marv;
    logic        e_mrrdy;
    logic [2:0]  e_sarrdy;
    logic [2:0]  e_srv;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] got_beats[$];
  logic [31:0] exp_beats[$];
  logic [31:0] addr_tab [3];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] arv, input logic [2:0] rrdy, input logic arrdy,
                     input logic rv, input logic rl, input logic [31:0] rd,
                     input logic [2:0] eg, input logic eb, input logic emarv,
                     input logic emrr, input logic [2:0] esar, input logic [2:0] esrv);
    vec_t v;
    v.arv = arv; v.rrdy = rrdy; v.arrdy = arrdy; v.rv = rv; v.rl = rl; v.rd = rd;
    v.e_grant = eg; v.e_busy = eb; v.e_marv = emarv; v.e_mrrdy = emrr;
    v.e_sarrdy = esar; v.e_srv = esrv;
    vecs.push_back(v);
  endtask

  function automatic int onehot_idx(input logic [2:0] g);
    return g[2] ? 2 : (g[1] ? 1 : 0);
  endfunction

  // One full transaction with a well-behaved slave; all masters ready for R.
  task automatic serve(input logic [2:0] exp_g, input int nbeats, input string tag);
    int cyc;
    int ok_beats;
    cyc = 0;
    ok_beats = 0;
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b0;
    m_if.rlast   = 1'b0;
    s_if.rready  = 3'b111;
    do begin
      @(negedge clk); #1; cyc++;
    end while (!m_if.arvalid[0] && cyc < 8);
    chk({tag, "_ar_seen"}, 32'(m_if.arvalid[0]), 32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    chk({tag, "_araddr"}, m_if.araddr, addr_tab[onehot_idx(exp_g)]);
    m_if.arready = 1'b1;
    @(negedge clk);
    m_if.arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      m_if.rvalid = 1'b1;
      m_if.rdata  = 32'hC000_0000 + 32'(b);
      m_if.rlast  = (b == nbeats - 1);
      #1;
      if (s_if.rvalid === exp_g) ok_beats++;
      @(negedge clk);
    end
    chk({tag, "_beats_to_owner"}, 32'(ok_beats), 32'(nbeats));
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    #1;
    chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    $display("txn %s: master %0d, %0d beats", tag, onehot_idx(exp_g), ok_beats);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g2;
    int         cyc;

    addr_tab[0] = 32'h1FC0_0000;
    addr_tab[1] = 32'h8000_1000;
    addr_tab[2] = 32'h0000_2000;
    s_if.arvalid = 3'b111;
    s_if.rready  = 3'b111;
    s_if.araddr  = {addr_tab[2], addr_tab[1], addr_tab[0]};
    s_if.arid    = {4'h2, 4'h1, 4'h0};
    s_if.arlen   = {4'd3, 4'd3, 4'd7};
    s_if.arsize  = {3'd2, 3'd2, 3'd2};
    s_if.arburst = {2'd1, 2'd1, 2'd1};
    s_if.arlock  = '0;
    s_if.arcache = '0;
    s_if.arprot  = '0;
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b0;
    m_if.rid     = 4'h0;
    m_if.rdata   = '0;
    m_if.rresp   = 2'b00;
    m_if.rlast   = 1'b0;

    // Reset state with every master requesting and the slave pushing a beat.
    m_if.rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_arvalid", 32'(m_if.arvalid[0]), 32'd0);
    chk("rst_m_rready", 32'(m_if.rready[0]), 32'd0);
    chk("rst_s_arready", 32'(s_if.arready), 32'd0);
    chk("rst_s_rvalid", 32'(s_if.rvalid), 32'd0);
    m_if.rvalid = 1'b0;
    s_if.arvalid = 3'b000;
    @(negedge clk);
    rst = 1'b0;

    // Vector table: single master 8-beat burst, then backpressured 4-beat burst.
    g2 = FIXPRIO ? 3'b001 : 3'b100;
    add(3'b001, 3'b000, 1, 0, 0, 0,             3'b000, 0, 0, 0, 3'b000, 3'b000);
    add(3'b001, 3'b001, 1, 1, 0, 32'hD000_0000, 3'b001, 1, 1, 0, 3'b001, 3'b000);
    for (int i = 0; i < 8; i++)
      add(3'b000, 3'b001, 0, 1, (i == 7), 32'hD000_0000 + 32'(i),
          3'b001, 1, 0, 1, 3'b000, 3'b001);
    add(3'b000, 3'b000, 0, 0, 0, 0,             3'b000, 0, 0, 0, 3'b000, 3'b000);
    add(3'b101, 3'b000, 0, 0, 0, 0,             3'b000, 0, 0, 0, 3'b000, 3'b000);
    add(3'b101, 3'b000, 0, 0, 0, 0,             g2,     1, 1, 0, 3'b000, 3'b000);
    add(3'b101, 3'b000, 1, 0, 0, 0,             g2,     1, 1, 0, g2,     3'b000);
    add(3'b000, g2,     0, 1, 0, 32'hA000_0000, g2,     1, 0, 1, 3'b000, g2);
    add(3'b000, 3'b000, 0, 1, 0, 32'hA000_0001, g2,     1, 0, 0, 3'b000, g2);
    add(3'b000, g2,     0, 1, 0, 32'hA000_0001, g2,     1, 0, 1, 3'b000, g2);
    add(3'b000, 3'b000, 0, 1, 0, 32'hA000_0002, g2,     1, 0, 0, 3'b000, g2);
    add(3'b000, g2,     0, 1, 0, 32'hA000_0002, g2,     1, 0, 1, 3'b000, g2);
    add(3'b000, 3'b000, 0, 1, 1, 32'hA000_0003, g2,     1, 0, 0, 3'b000, g2);
    add(3'b000, g2,     0, 1, 1, 32'hA000_0003, g2,     1, 0, 1, 3'b000, g2);
    add(3'b000, 3'b000, 0, 0, 0, 0,             3'b000, 0, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 8; i++) exp_beats.push_back(32'hD000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) exp_beats.push_back(32'hA000_0000 + 32'(i));

    foreach (vecs[i]) begin
      @(negedge clk);
      s_if.arvalid = vecs[i].arv;
      s_if.rready  = vecs[i].rrdy;
      m_if.arready = vecs[i].arrdy;
      m_if.rvalid  = vecs[i].rv;
      m_if.rlast   = vecs[i].rl;
      m_if.rdata   = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_m_arvalid", i), 32'(m_if.arvalid[0]), 32'(vecs[i].e_marv));
      chk($sformatf("v%0d_m_rready", i), 32'(m_if.rready[0]), 32'(vecs[i].e_mrrdy));
      chk($sformatf("v%0d_s_arready", i), 32'(s_if.arready), 32'(vecs[i].e_sarrdy));
      chk($sformatf("v%0d_s_rvalid", i), 32'(s_if.rvalid), 32'(vecs[i].e_srv));
      chk($sformatf("v%0d_m_araddr", i), m_if.araddr,
          vecs[i].e_marv ? addr_tab[onehot_idx(vecs[i].e_grant)] : addr_tab[0]);
      if (vecs[i].e_marv)
        chk($sformatf("v%0d_m_arlen", i), 32'(m_if.arlen),
            (vecs[i].e_grant == 3'b001) ? 32'd7 : 32'd3);
      if ((s_if.rvalid & s_if.rready) != 3'b000) got_beats.push_back(s_if.rdata);
      if (vecs[i].rl && vecs[i].rv && (vecs[i].rrdy != 3'b000))
        $display("txn table: master %0d burst complete", onehot_idx(vecs[i].e_grant));
    end
    chk("beat_count", 32'(got_beats.size()), 32'(exp_beats.size()));
    foreach (exp_beats[i])
      if (i < got_beats.size()) chk($sformatf("beat%0d_data", i), got_beats[i], exp_beats[i]);

    // Contention: all three request continuously, 4 beats each.
    s_if.arvalid = 3'b111;
    serve(3'b001, 4, "cont0");
    serve(FIXPRIO ? 3'b001 : 3'b010, 4, "cont1");
    serve(FIXPRIO ? 3'b001 : 3'b100, 4, "cont2");
    serve(3'b001, 4, "cont3");
    s_if.arvalid = 3'b000;

    // AR stall: slave withholds arready while the other masters request.
    s_if.arvalid = 3'b001;
    m_if.arready = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk); #1; cyc++;
    end while (!m_if.arvalid[0] && cyc < 8);
    s_if.arvalid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("stall%0d_grant", c), 32'(grant), 32'd1);
      chk($sformatf("stall%0d_m_arvalid", c), 32'(m_if.arvalid[0]), 32'd1);
      chk($sformatf("stall%0d_s_arready", c), 32'(s_if.arready), 32'd0);
    end
    s_if.arvalid = 3'b001;
    serve(3'b001, 2, "stall");
    s_if.arvalid = 3'b000;

    // Reset in the middle of an 8-beat burst from master 1.
    s_if.arvalid = 3'b010;
    s_if.rready  = 3'b010;
    cyc = 0;
    do begin
      @(negedge clk); #1; cyc++;
    end while (!m_if.arvalid[0] && cyc < 8);
    chk("rmb_grant", 32'(grant), 32'b010);
    m_if.arready = 1'b1;
    @(negedge clk);
    m_if.arready = 1'b0;
    s_if.arvalid = 3'b000;
    for (int b = 0; b < 2; b++) begin
      m_if.rvalid = 1'b1;
      m_if.rdata  = 32'hB000_0000 + 32'(b);
      m_if.rlast  = 1'b0;
      #1;
      chk($sformatf("rmb_beat%0d_rvalid", b), 32'(s_if.rvalid), 32'b010);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("rmb_grant_after_rst", 32'(grant), 32'd0);
    chk("rmb_m_rready_after_rst", 32'(m_if.rready[0]), 32'd0);
    chk("rmb_s_rvalid_after_rst", 32'(s_if.rvalid), 32'd0);
    chk("rmb_busy_after_rst", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_if.rvalid = 1'b0;
    s_if.arvalid = 3'b100;
    serve(3'b100, 2, "post_rst");
    s_if.arvalid = 3'b000;

    // 110 then 111: master 1 first; afterwards round-robin picks 2, fixed priority picks 0.
    s_if.arvalid = 3'b110;
    serve(3'b010, 2, "prio_a");
    s_if.arvalid = 3'b111;
    serve(FIXPRIO ? 3'b001 : 3'b100, 2, "prio_b");
    s_if.arvalid = 3'b000;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_bus_rr.md
Name: axi_rd_bus_rr

Overview:
- N-master to 1-slave AXI3 read-channel bus for the cache refill path (I-cache, D-cache, uncached load unit → single AXI read port).
- Replaces the fixed 2-master req/grnt scheme. Arbitration is driven directly by each master's arvalid, using a round-robin pointer.
- The grant is held for one complete transaction: AR handshake through the R beat carrying rlast.
- One transaction is outstanding at a time.

Parameters:
- N_MST, 3, number of masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ID_W, 4, ARID/RID width.
- IDX_W, $clog2(N_MST) (min 1), width of the grant index; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_arvalid  in  N_MST  per-master AR valid
- s_arready  out  N_MST  per-master AR ready
- s_arid  in  N_MST*ID_W  packed; master k occupies [k*ID_W +: ID_W]
- s_araddr  in  N_MST*ADDR_W  packed
- s_arlen  in  N_MST*4  packed
- s_arsize  in  N_MST*3  packed
- s_arburst  in  N_MST*2  packed
- s_arlock  in  N_MST*2  packed
- s_arcache  in  N_MST*4  packed
- s_arprot  in  N_MST*3  packed
- s_rvalid  out  N_MST  per-master R valid
- s_rready  in  N_MST  per-master R ready
- s_rid  out  ID_W  broadcast RID
- s_rdata  out  DATA_W  broadcast RDATA
- s_rresp  out  2  broadcast RRESP
- s_rlast  out  1  broadcast RLAST
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot  out  (per-field widths)  AR fields to slave
- m_arvalid  out  1  AR valid to slave
- m_arready  in  1  AR ready from slave
- m_rid, m_rdata, m_rresp, m_rlast, m_rvalid  in  (per-field widths)  R channel from slave
- m_rready  out  1  R ready to slave
- grant  out  N_MST  one-hot current owner; 0 when idle
- busy  out  1  high in ADDR or DATA state

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, grant=0, rr_ptr=0, busy=0, m_arvalid=0, m_rready=0, s_arready=0, s_rvalid=0. Reset mid-burst abandons the transaction; no beats are forwarded afterwards.
- State IDLE:
  - if any s_arvalid is set, choose the winner as the first set bit searching from rr_ptr upward, wrapping modulo N_MST.
  - register grant[winner]=1 and go to ADDR.
  - Arbitration latency is 1 cycle; no AR is forwarded in IDLE.
- State ADDR:
  - m_ar* = fields of the granted master; m_arvalid = s_arvalid[g]; s_arready[g] = m_arready. All other s_arready are 0.
  - on m_arvalid & m_arready, go to DATA.
  - If the granted master drops arvalid, stay in ADDR (no re-arbitration).
- State DATA:
  - m_rready = s_rready[g]; s_rvalid[g] = m_rvalid; all other s_rvalid are 0.
  - s_rid/s_rdata/s_rresp/s_rlast = m_r* (broadcast, qualified by s_rvalid).
  - on m_rvalid & m_rready & m_rlast: go to IDLE, rr_ptr = (g+1) mod N_MST, grant=0.
  - A new transaction therefore starts no earlier than 2 cycles after the rlast beat (IDLE + arbitration).
- m_ar* fields are driven from master 0 when not in ADDR. m_arvalid=0 outside ADDR.
- m_rready=0 outside DATA; stray slave R beats are stalled, never dropped silently.
- A beat arriving in the same cycle as the AR handshake is not accepted; acceptance starts in DATA.
- All muxing is combinational from the registered grant index. There is no combinational path from s_arvalid to m_arvalid within IDLE.

Optional Feature:
- AXI_RD_BUS_FIXPRIO_EN
- Defined: IDLE arbitration is fixed priority (lowest index wins, so master 0, the I-cache, is highest). rr_ptr is held at 0 and not updated.
- Undefined: round-robin as above.

Test Plan:
- Single master (N_MST=3): s_arvalid=001, araddr=0x1FC0_0000, arlen=7 → grant=001 after 1 cycle. m_araddr=0x1FC0_0000. Exactly 8 beats delivered to master 0 only. Return to IDLE, busy=0, rr_ptr=1.
- Contention: s_arvalid=111 held, arlen=3 each → grant order 001, 010, 100, 001. Each holds for exactly 4 beats. No s_rvalid on a non-granted master.
- Backpressure: granted master s_rready toggles 1,0,1,0 during a 4-beat burst → m_rready mirrors it. All 4 beats accepted in order, no beat lost or duplicated.
- AR stall: m_arready held 0 for 5 cycles while 2 other masters assert arvalid → grant unchanged. m_arvalid=1 throughout. Other masters' s_arready=0.
- Reset mid-burst: assert rst after beat 2 of 8 → same cycle: grant=0, m_rready=0, s_rvalid=0. After release, a new request from master 2 is granted normally.
- AXI_RD_BUS_FIXPRIO_EN defined, s_arvalid=110 then 111 → master 1 granted first. After its rlast, master 0 is granted ahead of master 2.
